mul_red_k_pipe: RTL and testbench

Pipelined modular multiplier front-end for the Kyber arithmetic path (q = 3329).
- Accepts two 12-bit coefficient operands per transaction through a valid/ready handshake.
- Forms the 24-bit product in a register that drives the product_i input of an internal red_K (Barrett) instance.
- Registers the 12-bit reduced result and presents it with a coefficient index tag through a downstream valid/ready handshake.
- Sits between the coefficient memory/NTT sequencer and pointwise-multiply consumers.

---
 rtl/mul_red_k_pipe.sv | 123 ++++++++++++
 tb/tb_mul_red_k_pipe.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mul_red_k_pipe.sv
// Three-stage Kyber modular multiplier: operand, product, Barrett-reduced result.
// Define MUL_RED_K_OPCHECK_EN to add a sticky err_o flag for operands >= Q.

module red_K #(
  parameter int Q = 3329
) (
  input  logic [23:0] product_i,
  output logic [11:0] result_o
);
  localparam logic [12:0] M = 13'((64'd1 << 24) / Q);
  localparam logic [25:0] QW = 26'(Q);

  logic [12:0] t;
  logic [25:0] r0, r1, r2;

  // Quotient estimate undershoots by at most 2, so two corrections suffice.
  always_comb begin
    t  = 13'((37'(product_i) * 37'(M)) >> 24);
    r0 = 26'(product_i) - 26'(t) * QW;
    r1 = (r0 >= QW) ? r0 - QW : r0;
    r2 = (r1 >= QW) ? r1 - QW : r1;
    result_o = 12'(r2);
  end
endmodule

module mul_red_k_pipe #(
  parameter int Q     = 3329,
  parameter int IDX_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [11:0]      a_i,
  input  logic [11:0]      b_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [11:0]      result_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o,
  input  logic             ready_i
`ifdef MUL_RED_K_OPCHECK_EN
  ,
  output logic             err_o
`endif
);
  logic             v1_q, v2_q, v3_q;
  logic [11:0]      a1_q, b1_q;
  logic [IDX_W-1:0] idx1_q, idx2_q, idx3_q;
  logic [23:0]      p2_q;
  logic [11:0]      r3_q;
  logic [11:0]      red_res;
  logic             adv1, adv2, adv3;
  logic             in_fire;

  assign adv3    = ~v3_q | ready_i;
  assign adv2    = ~v2_q | adv3;
  assign adv1    = ~v1_q | adv2;
  assign ready_o = adv1;
  assign in_fire = valid_i & adv1;

  red_K #(.Q(Q)) u_red (
    .product_i (p2_q),
    .result_o  (red_res)
  );

  // Payloads load only with a valid incoming beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      idx1_q <= '0;
      p2_q   <= '0;
      idx2_q <= '0;
      r3_q   <= '0;
      idx3_q <= '0;
    end else begin
      if (adv1) begin
        v1_q <= in_fire;
        if (in_fire) begin
          a1_q   <= a_i;
          b1_q   <= b_i;
          idx1_q <= idx_i;
        end
      end
      if (adv2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          p2_q   <= 24'(a1_q) * 24'(b1_q);
          idx2_q <= idx1_q;
        end
      end
      if (adv3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          r3_q   <= red_res;
          idx3_q <= idx2_q;
        end
      end
    end
  end

  assign result_o = r3_q;
  assign idx_o    = idx3_q;
  assign valid_o  = v3_q;

`ifdef MUL_RED_K_OPCHECK_EN
  localparam logic [11:0] QV = 12'(Q);
  logic err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (in_fire && (a_i >= QV || b_i >= QV)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`endif
endmodule

// File: tb/tb_mul_red_k_pipe.sv
// Randomized bench for mul_red_k_pipe against a queue-based occupancy model.
// Covers reset, latency, streaming, backpressure, mid-op reset and optional err_o.

module tb_mul_red_k_pipe;
  localparam int Q = 3329;
  localparam int IDX_W = 8;

  logic             clk = 1'b0;
  logic             rst_i;
  logic [11:0]      a_i, b_i;
  logic [IDX_W-1:0] idx_i;
  logic             valid_i, ready_i;
  logic             ready_o, valid_o;
  logic [11:0]      result_o;
  logic [IDX_W-1:0] idx_o;
`ifdef MUL_RED_K_OPCHECK_EN
  logic             err_o;
`endif

  mul_red_k_pipe #(.Q(Q), .IDX_W(IDX_W)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .idx_i    (idx_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .result_o (result_o),
    .idx_o    (idx_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i)
`ifdef MUL_RED_K_OPCHECK_EN
    ,
    .err_o    (err_o)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Model: in-flight ops in FIFO order, each with its stage (1..3).
  int exp_r[$];
  int exp_i[$];
  int pos[$];

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // One cycle: drive, check, clock, update model. Called just after negedge.
  task automatic step(input bit v, input int a, input int b,
                      input int idx, input bit rdy, output bit acc);
    bit ev, er, out_x;
    int lim;
    valid_i = v;
    a_i     = 12'(a);
    b_i     = 12'(b);
    idx_i   = IDX_W'(idx);
    ready_i = rdy;
    #1;
    ev = (pos.size() > 0) && (pos[0] == 3);
    er = (pos.size() < 3) || rdy;
    chk("valid_o", int'(valid_o), int'(ev));
    chk("ready_o", int'(ready_o), int'(er));
    if (ev) begin
      chk("result_o", int'(result_o), exp_r[0]);
      chk("idx_o", int'(idx_o), exp_i[0]);
    end
    acc   = v && er;
    out_x = ev && rdy;
    @(posedge clk);
    if (out_x) begin
      void'(exp_r.pop_front());
      void'(exp_i.pop_front());
      void'(pos.pop_front());
    end
    for (int i = 0; i < pos.size(); i++) begin
      lim = (i == 0) ? 3 : pos[i-1] - 1;
      if (pos[i] + 1 <= lim) pos[i] = pos[i] + 1;
    end
    if (acc) begin
      exp_r.push_back((a * b) % Q);
      exp_i.push_back(idx % (1 << IDX_W));
      pos.push_back(1);
    end
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    bit acc;
    repeat (n) step(1'b0, 0, 0, 0, 1'b1, acc);
  endtask

  task automatic do_reset(input int n);
    rst_i   = 1'b1;
    valid_i = 1'b1;
    a_i     = 12'd7;
    b_i     = 12'd9;
    idx_i   = 8'd3;
    ready_i = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst_i   = 1'b0;
    valid_i = 1'b0;
    exp_r.delete();
    exp_i.delete();
    pos.delete();
    #1;
    chk("rst valid_o", int'(valid_o), 0);
    chk("rst result_o", int'(result_o), 0);
    chk("rst idx_o", int'(idx_o), 0);
    chk("rst ready_o", int'(ready_o), 1);
  endtask

  int sa[5] = '{17, 1665, 3000, 0, 1};
  int sb[5] = '{17, 2, 3000, 1234, 2280};
  int ba[4] = '{2, 3, 4, 5};
  int bb[4] = '{1234, 1000, 900, 5};

  initial begin
    bit acc;
    int k;
    rst_i   = 1'b1;
    valid_i = 1'b1;
    a_i     = '0;
    b_i     = '0;
    idx_i   = '0;
    ready_i = 1'b1;
    @(negedge clk);

    do_reset(2);
    drain(4);

    step(1'b1, 3328, 3328, 5, 1'b1, acc);
    chk("single acc", int'(acc), 1);
    drain(5);

    for (int i = 0; i < 5; i++) step(1'b1, sa[i], sb[i], i, 1'b1, acc);
    drain(5);

    k = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, ba[k], bb[k], 10 + k, 1'b0, acc);
      if (acc) k++;
    end
    chk("capacity", k, 3);
    chk("held result", int'(result_o), 2468);
    for (int c = 0; c < 10 && k < 4; c++) begin
      step(1'b1, ba[k], bb[k], 10 + k, 1'b1, acc);
      if (acc) k++;
    end
    chk("bp all acc", k, 4);
    drain(5);

    step(1'b1, 100, 200, 20, 1'b1, acc);
    step(1'b1, 300, 400, 21, 1'b1, acc);
    do_reset(1);
    step(1'b1, 17, 17, 22, 1'b1, acc);
    drain(5);

    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, Q - 1)),
           int'($urandom_range(0, Q - 1)), int'($urandom_range(0, 255)),
           1'($urandom_range(0, 2) != 0), acc);
    end
    drain(6);
    chk("drained", pos.size(), 0);

`ifdef MUL_RED_K_OPCHECK_EN
    do_reset(1);
    chk("err clear", int'(err_o), 0);
    step(1'b1, 3329, 1, 9, 1'b1, acc);
    chk("err set", int'(err_o), 1);
    step(1'b1, 5, 6, 10, 1'b1, acc);
    drain(5);
    chk("err sticky", int'(err_o), 1);
    do_reset(1);
    chk("err rst", int'(err_o), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
